fetch_stage: RTL and testbench

Instruction-fetch stage of the two-stage core, directly upstream of the EX-stage control unit. It owns the program counter and drives the synchronous-read instruction memory. It presents each fetched instruction to EX with its PC and a squash flag (`stall_EX`), and applies jal/jalr redirects one cycle late through a registered target. The control unit's `stall_FETCH`/`pcsrc` outputs close the loop.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, EX-stage presentation and
// control-unit feedback. The master side is the fetch stage itself.
interface fetch_stage_if #(
    parameter int unsigned IMEM_AW = 12
);
    logic               stall_FETCH;
    logic [1:0]         pcsrc;
    logic [31:0]        pc_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        instr_EX;
    logic [31:0]        pc_EX;
    logic [31:0]        pc_plus4_EX;
    logic               stall_EX;
    logic               misalign_err;

    modport master (
        input  stall_FETCH, pcsrc, pc_target, imem_rdata,
        output imem_addr, instr_EX, pc_EX, pc_plus4_EX, stall_EX, misalign_err
    );

    modport slave (
        output stall_FETCH, pcsrc, pc_target, imem_rdata,
        input  imem_addr, instr_EX, pc_EX, pc_plus4_EX, stall_EX, misalign_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read imem and
// applies jal/jalr redirects one cycle late through a registered target.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets
// go to TRAP_PC and raise a sticky misalign_err).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 12,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        boot_q;
    logic        redir_q, redir_d;
    logic        stall_q, stall_d;
    logic        redirect;
    logic        tgt_misaligned;

    // Next-state: redirect accept, next PC priority and squash generation
    always_comb begin
        redirect       = (bus.pcsrc != 2'd0) && !stall_q && !boot_q;
        tgt_misaligned = (bus.pc_target[1:0] != 2'b00);

        if (boot_q) begin
            pc_d = RESET_PC;
        end else if (redir_q) begin
            pc_d = tgt_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end

        redir_d = redirect;
        tgt_d   = tgt_q;
        if (redirect) begin
            if (TRAP_EN && tgt_misaligned) begin
                tgt_d = TRAP_PC;
            end else begin
                tgt_d = bus.pc_target & 32'hFFFF_FFFC;
            end
        end

        // A squashed slot never squashes its successor
        stall_d = !boot_q && !stall_q && (redirect || bus.stall_FETCH);
    end

    // PC, boot, pending-redirect and squash registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            boot_q  <= 1'b1;
            redir_q <= 1'b0;
            tgt_q   <= '0;
            stall_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            boot_q  <= 1'b0;
            redir_q <= redir_d;
            tgt_q   <= tgt_d;
            stall_q <= stall_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_q, err_d;

    // Sticky misaligned-target flag, cleared only by reset
    always_comb begin
        err_d = err_q | (redirect && tgt_misaligned);
    end

    // Error flag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.misalign_err = err_q;
`else
    assign bus.misalign_err = 1'b0;
`endif

    // imem address comes from state only, never from pc_target/pcsrc
    assign bus.imem_addr   = pc_d[IMEM_AW+1:2];
    assign bus.instr_EX    = bus.imem_rdata;
    assign bus.pc_EX       = pc_q;
    assign bus.pc_plus4_EX = pc_q + 32'd4;
    assign bus.stall_EX    = stall_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table with a
// one-cycle-latency scoreboard, plus a hand-written reset/throughput run.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP   = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] TP  = TRAP;
    localparam logic        MIS = 1'b1;
`else
    localparam logic [31:0] TP  = 32'h0000_0040;
    localparam logic        MIS = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        sf;
        logic [1:0]  ps;
        logic [31:0] tg;
        logic        es;
        logic [31:0] ep;
        logic        em;
        logic        ca;
        logic [31:0] ea;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] mem [4096];
    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    fetch_stage_if #(.IMEM_AW(12)) bus ();

    fetch_stage #(
        .RESET_PC(RST_PC),
        .IMEM_AW (12),
        .TRAP_PC (TRAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic r, input logic sf, input logic [1:0] ps,
                           input logic [31:0] tg, input logic es, input logic [31:0] ep,
                           input logic em, input logic ca, input logic [31:0] ea);
        vec_t v;
        v.rst_n = r; v.sf = sf; v.ps = ps; v.tg = tg;
        v.es = es; v.ep = ep; v.em = em; v.ca = ca; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic compare_out(input vec_t e, input int idx);
        logic [31:0] word;
        word = {18'd0, e.ep[13:2]};
        check($sformatf("row%0d pc_EX", idx), bus.pc_EX, e.ep);
        check($sformatf("row%0d stall_EX", idx), {31'd0, bus.stall_EX}, {31'd0, e.es});
        check($sformatf("row%0d pc_plus4_EX", idx), bus.pc_plus4_EX, e.ep + 32'd4);
        check($sformatf("row%0d misalign_err", idx), {31'd0, bus.misalign_err}, {31'd0, e.em});
        if (!e.es)
            check($sformatf("row%0d instr_EX", idx), bus.instr_EX, word);
        if (e.ca)
            check($sformatf("row%0d imem_addr", idx), {20'd0, bus.imem_addr}, {20'd0, e.ea[13:2]});
    endtask

    initial begin
        vec_t e;
        logic [31:0] exp_pc;
        for (int i = 0; i < 4096; i++) mem[i] = i;
        rst_n = 1'b0;
        bus.stall_FETCH = 1'b0;
        bus.pcsrc = 2'd0;
        bus.pc_target = '0;

        //      rst sf ps  target        es  pc_EX next      mis  ca  imem byte addr
        add_row(1, 0, 0, 32'h0,     0, 32'h0,      0,   1, 32'h4);
        add_row(1, 0, 0, 32'h0,     0, 32'h4,      0,   0, 32'h0);
        add_row(1, 0, 0, 32'h0,     0, 32'h8,      0,   0, 32'h0);
        add_row(1, 1, 1, 32'h40,    1, 32'hC,      0,   1, 32'h40);
        add_row(1, 0, 1, 32'h200,   0, 32'h40,     0,   1, 32'h44);
        add_row(1, 0, 0, 32'h0,     0, 32'h44,     0,   0, 32'h0);
        add_row(1, 0, 2, 32'h40,    1, 32'h48,     0,   1, 32'h40);
        add_row(1, 0, 0, 32'h0,     0, 32'h40,     0,   0, 32'h0);
        add_row(1, 0, 1, 32'h80,    1, 32'h44,     0,   1, 32'h80);
        add_row(1, 0, 0, 32'h0,     0, 32'h80,     0,   0, 32'h0);
        add_row(1, 0, 1, 32'h10,    1, 32'h84,     0,   1, 32'h10);
        add_row(1, 0, 0, 32'h0,     0, 32'h10,     0,   0, 32'h0);
        add_row(1, 0, 0, 32'h0,     0, 32'h14,     0,   0, 32'h0);
        add_row(1, 1, 0, 32'h0,     1, 32'h18,     0,   1, 32'h1C);
        add_row(1, 1, 0, 32'h0,     0, 32'h1C,     0,   0, 32'h0);
        add_row(1, 0, 0, 32'h0,     0, 32'h20,     0,   0, 32'h0);
        add_row(1, 0, 3, 32'h300,   1, 32'h24,     0,   1, 32'h300);
        add_row(1, 0, 0, 32'h0,     0, 32'h300,    0,   0, 32'h0);
        add_row(1, 0, 1, 32'h100,   1, 32'h304,    0,   0, 32'h0);
        add_row(0, 0, 0, 32'h0,     1, RST_PC,     0,   1, RST_PC);
        add_row(1, 0, 0, 32'h0,     0, RST_PC,     0,   0, 32'h0);
        add_row(1, 0, 0, 32'h0,     0, 32'h4,      0,   0, 32'h0);
        add_row(1, 0, 2, 32'h42,    1, 32'h8,      MIS, 1, TP);
        add_row(1, 0, 0, 32'h0,     0, TP,         MIS, 0, 32'h0);
        add_row(1, 0, 0, 32'h0,     0, TP + 32'h4, MIS, 0, 32'h0);
        add_row(1, 0, 1, 32'h8,     1, TP + 32'h8, MIS, 1, 32'h8);
        add_row(1, 0, 0, 32'h0,     0, 32'h8,      MIS, 0, 32'h0);
        add_row(1, 0, 0, 32'h0,     0, 32'hC,      MIS, 0, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset stall_EX", {31'd0, bus.stall_EX}, 32'd1);
        check("reset pc_EX", bus.pc_EX, RST_PC);
        check("reset pc_plus4_EX", bus.pc_plus4_EX, RST_PC + 32'd4);
        check("reset misalign_err", {31'd0, bus.misalign_err}, 32'd0);
        check("reset imem_addr", {20'd0, bus.imem_addr}, {20'd0, RST_PC[13:2]});

        foreach (vecs[i]) begin
            rst_n           = vecs[i].rst_n;
            bus.stall_FETCH = vecs[i].sf;
            bus.pcsrc       = vecs[i].ps;
            bus.pc_target   = vecs[i].tg;
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            compare_out(e, i);
        end
        check("scoreboard drained", sb.size(), 32'd0);

        // Hand-written: two-cycle reset mid-stream, then a long sequential run
        bus.stall_FETCH = 1'b0;
        bus.pcsrc = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset2 stall_EX", {31'd0, bus.stall_EX}, 32'd1);
        check("reset2 misalign_err", {31'd0, bus.misalign_err}, 32'd0);
        rst_n = 1'b1;
        exp_pc = RST_PC;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("seq%0d pc_EX", c), bus.pc_EX, exp_pc);
            check($sformatf("seq%0d stall_EX", c), {31'd0, bus.stall_EX}, 32'd0);
            check($sformatf("seq%0d instr_EX", c), bus.instr_EX, {18'd0, exp_pc[13:2]});
            exp_pc = exp_pc + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
